// File: rtl/ctrl_rx_pkg.sv
// Shared definitions for the system controller: command codes, operand
// addresses and the RX decoder state encoding.
package ctrl_rx_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8
    } ctrl_rx_state_e;

    function automatic logic is_alu_phase(input ctrl_rx_state_e s);
        return (s == FUN) || (s == ALU_WAIT);
    endfunction

endpackage

// File: rtl/ctrl_rx_timer.sv
// Wait-state watchdog: cleared on entry to a wait state, counts while waiting,
// flags the last permitted cycle.
module ctrl_rx_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Expire on the cycle whose edge would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/ctrl_rx.sv
// Receive-side command decoder: turns UART command frames into RF writes/reads
// and ALU operations, and hands read/ALU results to the TX controller.
module ctrl_rx
    import ctrl_rx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR    = 4,
    parameter int FUN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     UART_RX_DATA,
    input  logic                 UART_RX_VLD,
    input  logic [WIDTH-1:0]     RF_RdData,
    input  logic                 RF_RdData_VLD,
    input  logic [2*WIDTH-1:0]   ALU_OUT,
    input  logic                 ALU_OUT_VLD,
    output logic                 RF_WrEn,
    output logic                 RF_RdEn,
    output logic [ADDR-1:0]      RF_Address,
    output logic [WIDTH-1:0]     RF_WrData,
    output logic                 ALU_EN,
    output logic [FUN_W-1:0]     ALU_FUN,
    output logic                 CLK_GATE_EN,
    output logic                 UART_RF_SEND,
    output logic [WIDTH-1:0]     UART_SEND_RF_DATA,
    output logic                 UART_ALU_SEND,
    output logic [2*WIDTH-1:0]   UART_SEND_ALU_DATA
);

    ctrl_rx_state_e state_q, state_d;
    logic [ADDR-1:0]    addr_q, addr_d;
    logic               wren_q, wren_d;
    logic               rden_q, rden_d;
    logic [ADDR-1:0]    rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]   wrdata_q, wrdata_d;
    logic               alu_en_q, alu_en_d;
    logic [FUN_W-1:0]   alu_fun_q, alu_fun_d;
    logic               gate_q, gate_d;
    logic               rf_send_q, rf_send_d;
    logic [WIDTH-1:0]   rf_data_q, rf_data_d;
    logic               alu_send_q, alu_send_d;
    logic [2*WIDTH-1:0] alu_data_q, alu_data_d;

    logic tmr_clr, tmr_inc, tmr_exp;

    ctrl_rx_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .expire_o (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wren_d     = 1'b0;
        rden_d     = 1'b0;
        rf_addr_d  = rf_addr_q;
        wrdata_d   = wrdata_q;
        alu_en_d   = 1'b0;
        alu_fun_d  = alu_fun_q;
        rf_send_d  = 1'b0;
        rf_data_d  = rf_data_q;
        alu_send_d = 1'b0;
        alu_data_d = alu_data_q;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (UART_RX_VLD) begin
                    if (UART_RX_DATA == WIDTH'(CMD_RF_WR)) begin
                        state_d = WR_ADDR;
                    end else if (UART_RX_DATA == WIDTH'(CMD_RF_RD)) begin
                        state_d = RD_ADDR;
                    end else if (UART_RX_DATA == WIDTH'(CMD_ALU_OP)) begin
                        state_d = OPA;
                    end else if (UART_RX_DATA == WIDTH'(CMD_ALU_NOP)) begin
                        state_d = FUN;
                    end
                end
            end
            WR_ADDR: begin
                if (UART_RX_VLD) begin
                    addr_d  = UART_RX_DATA[ADDR-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (UART_RX_VLD) begin
                    wren_d    = 1'b1;
                    rf_addr_d = addr_q;
                    wrdata_d  = UART_RX_DATA;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (UART_RX_VLD) begin
                    rden_d    = 1'b1;
                    rf_addr_d = UART_RX_DATA[ADDR-1:0];
                    tmr_clr   = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                tmr_inc = 1'b1;
                // A valid strobe on the expiring cycle still gets sent.
                if (RF_RdData_VLD) begin
                    rf_send_d = 1'b1;
                    rf_data_d = RF_RdData;
                    state_d   = IDLE;
                end else if (tmr_exp) begin
                    state_d = IDLE;
                end
            end
            OPA: begin
                if (UART_RX_VLD) begin
                    wren_d    = 1'b1;
                    rf_addr_d = ADDR'(OPA_ADDR);
                    wrdata_d  = UART_RX_DATA;
                    state_d   = OPB;
                end
            end
            OPB: begin
                if (UART_RX_VLD) begin
                    wren_d    = 1'b1;
                    rf_addr_d = ADDR'(OPB_ADDR);
                    wrdata_d  = UART_RX_DATA;
                    state_d   = FUN;
                end
            end
            FUN: begin
                if (UART_RX_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = UART_RX_DATA[FUN_W-1:0];
                    tmr_clr   = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                tmr_inc = 1'b1;
                if (ALU_OUT_VLD) begin
                    alu_send_d = 1'b1;
                    alu_data_d = ALU_OUT;
                    state_d    = IDLE;
                end else if (tmr_exp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ALU_EN is only raised on entry to ALU_WAIT, so this covers its cycle too.
        gate_d = is_alu_phase(state_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            rf_addr_q  <= '0;
            wrdata_q   <= '0;
            alu_en_q   <= 1'b0;
            alu_fun_q  <= '0;
            gate_q     <= 1'b0;
            rf_send_q  <= 1'b0;
            rf_data_q  <= '0;
            alu_send_q <= 1'b0;
            alu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            rf_addr_q  <= rf_addr_d;
            wrdata_q   <= wrdata_d;
            alu_en_q   <= alu_en_d;
            alu_fun_q  <= alu_fun_d;
            gate_q     <= gate_d;
            rf_send_q  <= rf_send_d;
            rf_data_q  <= rf_data_d;
            alu_send_q <= alu_send_d;
            alu_data_q <= alu_data_d;
        end
    end

    assign RF_WrEn            = wren_q;
    assign RF_RdEn            = rden_q;
    assign RF_Address         = rf_addr_q;
    assign RF_WrData          = wrdata_q;
    assign ALU_EN             = alu_en_q;
    assign ALU_FUN            = alu_fun_q;
    assign CLK_GATE_EN        = gate_q;
    assign UART_RF_SEND       = rf_send_q;
    assign UART_SEND_RF_DATA  = rf_data_q;
    assign UART_ALU_SEND      = alu_send_q;
    assign UART_SEND_ALU_DATA = alu_data_q;

endmodule

// File: tb/tb_ctrl_rx.sv
// Scoreboard bench for ctrl_rx: directed command frames push expected strobe
// events; a negedge monitor pops and compares every strobe the DUT raises.
module tb_ctrl_rx;

    localparam int WIDTH   = 8;
    localparam int ADDR    = 4;
    localparam int FUN_W   = 4;
    localparam int TIMEOUT = 255;

    localparam logic [2:0] EV_WR      = 3'd0;
    localparam logic [2:0] EV_RD      = 3'd1;
    localparam logic [2:0] EV_ALUEN   = 3'd2;
    localparam logic [2:0] EV_RFSEND  = 3'd3;
    localparam logic [2:0] EV_ALUSEND = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  addr;
        logic [15:0] val;
    } ev_t;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [WIDTH-1:0]     UART_RX_DATA = '0;
    logic                 UART_RX_VLD = 1'b0;
    logic [WIDTH-1:0]     RF_RdData = '0;
    logic                 RF_RdData_VLD = 1'b0;
    logic [2*WIDTH-1:0]   ALU_OUT = '0;
    logic                 ALU_OUT_VLD = 1'b0;
    logic                 RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN;
    logic [ADDR-1:0]      RF_Address;
    logic [WIDTH-1:0]     RF_WrData;
    logic [FUN_W-1:0]     ALU_FUN;
    logic                 UART_RF_SEND, UART_ALU_SEND;
    logic [WIDTH-1:0]     UART_SEND_RF_DATA;
    logic [2*WIDTH-1:0]   UART_SEND_ALU_DATA;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    ctrl_rx #(
        .WIDTH(WIDTH), .ADDR(ADDR), .FUN_W(FUN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .UART_RF_SEND(UART_RF_SEND), .UART_SEND_RF_DATA(UART_SEND_RF_DATA),
        .UART_ALU_SEND(UART_ALU_SEND), .UART_SEND_ALU_DATA(UART_SEND_ALU_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [3:0] addr, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string name, input logic [2:0] kind,
                             input logic [3:0] addr, input logic [15:0] val);
        ev_t e;
        ev_t a;
        a.kind = kind;
        a.addr = addr;
        a.val  = val;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_%s: got %0h expected no event", name, a);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(a), 64'(e));
        end
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WrEn)       pop_check("rf_wr",    EV_WR,      RF_Address, {8'h00, RF_WrData});
            if (RF_RdEn)       pop_check("rf_rd",    EV_RD,      RF_Address, 16'h0000);
            if (ALU_EN)        pop_check("alu_en",   EV_ALUEN,   4'h0,       {12'h000, ALU_FUN});
            if (UART_RF_SEND)  pop_check("rf_send",  EV_RFSEND,  4'h0,       {8'h00, UART_SEND_RF_DATA});
            if (UART_ALU_SEND) pop_check("alu_send", EV_ALUSEND, 4'h0,       UART_SEND_ALU_DATA);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        UART_RX_DATA = b;
        UART_RX_VLD  = 1'b1;
        @(negedge CLK);
        UART_RX_VLD  = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        RF_RdData     = d;
        RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        ALU_OUT     = d;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
                    UART_RF_SEND, UART_SEND_RF_DATA, UART_ALU_SEND, UART_SEND_ALU_DATA});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        check("reset_outputs", all_outs(), 64'h0);
        RST = 1'b1;
        idle(2);

        // 1: RF write
        push(EV_WR, 4'h5, 16'h003C);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        idle(2);
        check("wr_hold_addr", 64'(RF_Address), 64'h5);

        // 2: RF read, data returns 3 cycles later
        push(EV_RD, 4'h7, 16'h0000);
        push(EV_RFSEND, 4'h0, 16'h003C);
        send_byte(8'hBB); send_byte(8'hF7);
        idle(3);
        pulse_rd(8'h3C);
        idle(2);
        check("rd_hold_addr", 64'(RF_Address), 64'h7);

        // 3: full ALU op with clock-gate tracking
        push(EV_WR, 4'h0, 16'h0012);
        push(EV_WR, 4'h1, 16'h0034);
        push(EV_ALUEN, 4'h0, 16'h0000);
        push(EV_ALUSEND, 4'h0, 16'h0046);
        send_byte(8'hCC); send_byte(8'h12);
        check("gate_opb", 64'(CLK_GATE_EN), 64'h0);
        send_byte(8'h34);
        check("gate_fun", 64'(CLK_GATE_EN), 64'h1);
        send_byte(8'h00);
        check("gate_alu_en", 64'(CLK_GATE_EN), 64'h1);
        idle(2);
        check("gate_alu_wait", 64'(CLK_GATE_EN), 64'h1);
        pulse_alu(16'h0046);
        check("gate_after_send", 64'(CLK_GATE_EN), 64'h0);
        idle(2);

        // 4: ALU no-operand op
        push(EV_ALUEN, 4'h0, 16'h0002);
        push(EV_ALUSEND, 4'h0, 16'h1234);
        send_byte(8'hDD); send_byte(8'h02);
        idle(1);
        pulse_alu(16'h1234);
        idle(3);
        check("alu_fun_hold", 64'(ALU_FUN), 64'h2);
        check("alu_data_hold", 64'(UART_SEND_ALU_DATA), 64'h1234);

        // 5: unknown byte ignored, then write; bytes during RD_WAIT dropped
        push(EV_WR, 4'h3, 16'h0099);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h99);
        idle(2);
        push(EV_RD, 4'h2, 16'h0000);
        push(EV_RFSEND, 4'h0, 16'h0077);
        send_byte(8'hBB); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        pulse_rd(8'h77);
        idle(3);

        // 6a: timeout with no strobe, late strobe ignored, decoder back in IDLE
        push(EV_RD, 4'h3, 16'h0000);
        send_byte(8'hBB); send_byte(8'h03);
        idle(TIMEOUT + 5);
        pulse_rd(8'hEE);
        push(EV_WR, 4'h4, 16'h0011);
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
        idle(2);
        check("rf_data_after_timeout", 64'(UART_SEND_RF_DATA), 64'h77);

        // Boundary: strobe on the expiring cycle wins, one cycle later is too late
        push(EV_RD, 4'h2, 16'h0000);
        push(EV_RFSEND, 4'h0, 16'h005A);
        send_byte(8'hBB); send_byte(8'h02);
        idle(TIMEOUT - 1);
        pulse_rd(8'h5A);
        idle(2);
        push(EV_RD, 4'h2, 16'h0000);
        send_byte(8'hBB); send_byte(8'h02);
        idle(TIMEOUT);
        pulse_rd(8'hA5);
        idle(2);
        check("rf_data_late_dropped", 64'(UART_SEND_RF_DATA), 64'h5A);

        // ALU wait timeout
        push(EV_ALUEN, 4'h0, 16'h0003);
        send_byte(8'hDD); send_byte(8'h03);
        idle(TIMEOUT + 3);
        check("gate_after_alu_timeout", 64'(CLK_GATE_EN), 64'h0);
        pulse_alu(16'hBEEF);
        idle(2);

        // 6b: reset mid-frame discards the partial write
        send_byte(8'hAA); send_byte(8'h05);
        RST = 1'b0;
        idle(1);
        check("midframe_reset_outputs", all_outs(), 64'h0);
        RST = 1'b1;
        idle(1);
        send_byte(8'h3C);
        idle(3);
        push(EV_WR, 4'h6, 16'h0077);
        send_byte(8'hAA); send_byte(8'h06); send_byte(8'h77);
        idle(3);

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
